// File: rtl/constraint_sweep_driver.sv
`default_nettype none
// ============================================================================
// Module      : constraint_sweep_driver
// Description : Walks packed candidates (seed, seed+1, ...) into a
//               combinational constraint evaluator. Stops on the first
//               satisfying candidate, on an exhausted try budget, or on abort.
// Revision    : 1.0 - initial release
// ============================================================================
module constraint_sweep_driver #(
  parameter int CAND_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CAND_W-1:0] seed,
  input  logic [CNT_W-1:0]  max_tries,
  input  logic              sat,
  output logic [CAND_W-1:0] cand,
  output logic              cand_valid,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [CAND_W-1:0] hit_cand,
  output logic [CNT_W-1:0]  tries
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_q,  state_d;
  logic [CAND_W-1:0] cand_q,   cand_d;
  logic [CAND_W-1:0] hit_q,    hit_d;
  logic [CNT_W-1:0]  tries_q,  tries_d;
  logic [CNT_W-1:0]  budget_q, budget_d;
  logic              found_q,  found_d;

  logic [CNT_W-1:0]  tries_inc;
  logic              last_try;

  // The try being evaluated this cycle is the last one the budget allows.
  assign tries_inc = tries_q + CNT_W'(1);
  assign last_try  = (tries_inc == budget_q);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cand_q   <= '0;
      hit_q    <= '0;
      tries_q  <= '0;
      budget_q <= '0;
      found_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      hit_q    <= hit_d;
      tries_q  <= tries_d;
      budget_q <= budget_d;
      found_q  <= found_d;
    end
  end

  // Next-state decision; a zero budget skips RUN entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (max_tries == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (sat || abort || last_try) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath updates: sat outranks abort, abort outranks budget exhaustion.
  always_comb begin
    cand_d   = cand_q;
    hit_d    = hit_q;
    tries_d  = tries_q;
    budget_d = budget_q;
    found_d  = found_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cand_d   = seed;
          budget_d = max_tries;
          tries_d  = '0;
          found_d  = 1'b0;
          hit_d    = '0;
        end
      end
      ST_RUN: begin
        if (sat) begin
          hit_d   = cand_q;
          found_d = 1'b1;
          tries_d = tries_inc;
        end else if (abort) begin
          found_d = 1'b0;
        end else if (last_try) begin
          tries_d = tries_inc;
        end else begin
          tries_d = tries_inc;
          cand_d  = cand_q + CAND_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    cand_valid = (state_q == ST_RUN);
    busy       = (state_q == ST_RUN) || (state_q == ST_DONE);
    done       = (state_q == ST_DONE);
  end

  assign cand     = cand_q;
  assign hit_cand = hit_q;
  assign tries    = tries_q;
  assign found    = found_q;

endmodule
`default_nettype wire

// File: tb/tb_constraint_sweep_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_constraint_sweep_driver
// Description : Directed and randomized sweeps of constraint_sweep_driver
//               against a behavioural outcome model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_constraint_sweep_driver;

  localparam int CAND_W = 8;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [CAND_W-1:0] seed = '0;
  logic [CNT_W-1:0]  max_tries = '0;
  logic              sat;
  logic [CAND_W-1:0] cand;
  logic              cand_valid;
  logic              busy;
  logic              done;
  logic              found;
  logic [CAND_W-1:0] hit_cand;
  logic [CNT_W-1:0]  tries;

  // Evaluator stand-in: satisfied by a single target value when enabled.
  logic              sat_en = 1'b0;
  logic [CAND_W-1:0] target = '0;
  assign sat = sat_en & (cand == target);

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  constraint_sweep_driver #(.CAND_W(CAND_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .seed       (seed),
    .max_tries  (max_tries),
    .sat        (sat),
    .cand       (cand),
    .cand_valid (cand_valid),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .hit_cand   (hit_cand),
    .tries      (tries)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Outcome of a sweep from the rules: scan candidate indices in order and
  // stop on the first hit, abort or budget end; done lands one cycle later.
  task automatic model(input logic [7:0] s, input int b, input logic [7:0] tgt,
                       input bit sen, input int ab,
                       output bit f, output int t, output logic [7:0] h,
                       output logic [7:0] last, output int dc);
    logic [7:0] c;
    f = 0; t = 0; h = 8'h00; last = s; dc = 1;
    if (b != 0) begin
      for (int i = 0; i < b; i++) begin
        c = s + 8'(i);
        last = c;
        if (sen && c == tgt) begin
          f = 1; t = i + 1; h = c; dc = i + 2; break;
        end
        if (i == ab) begin
          t = i; dc = i + 2; break;
        end
        if (i + 1 == b) begin
          t = b; dc = b + 1;
        end
      end
    end
  endtask

  // One sweep: ab = candidate index carrying abort, st_at = index carrying a
  // spurious start (-1 for none).
  task automatic sweep(input logic [7:0] s, input int b, input logic [7:0] tgt,
                       input bit sen, input int ab, input int st_at);
    bit         ef;
    int         et, edc, c, dc_obs, done_cnt, idx;
    logic [7:0] eh, elast, ecand;
    model(s, b, tgt, sen, ab, ef, et, eh, elast, edc);
    sat_en = sen;
    target = tgt;
    @(negedge clk);
    start = 1'b1; seed = s; max_tries = 16'(b);
    @(posedge clk); #1;
    start = 1'b0; seed = ~s; max_tries = 16'($urandom_range(1, 200));
    c = 1; dc_obs = 0; done_cnt = 0; idx = 0;
    while (c <= b + 20 && dc_obs == 0) begin
      abort = (c - 1 == ab);
      start = (c - 1 == st_at);
      @(negedge clk);
      if (cand_valid) begin
        ecand = s + 8'(idx);
        check("cand_seq", 64'(cand), 64'(ecand));
        idx++;
      end
      if (done) begin
        dc_obs = c;
        done_cnt++;
      end
      @(posedge clk); #1;
      c++;
    end
    abort = 1'b0;
    start = 1'b0;
    check("done_cycle", 64'(dc_obs), 64'(edc));
    check("run_cycles", 64'(idx), 64'(edc - 1));
    @(negedge clk);
    check("found", 64'(found), 64'(ef));
    check("tries", 64'(tries), 64'(et));
    check("hit_cand", 64'(hit_cand), 64'(eh));
    check("cand_hold", 64'(cand), 64'(elast));
    check("busy_after", 64'(busy), 64'(0));
    for (int k = 0; k < 2; k++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    check("done_once", 64'(done_cnt), 64'(1));
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_cand", 64'(cand), 64'(0));
    check("rst_hit", 64'(hit_cand), 64'(0));
    check("rst_tries", 64'(tries), 64'(0));
    check("rst_flags", 64'({cand_valid, busy, done, found}), 64'(0));

    // Hit on 0x15 from seed 0x10: tries 6, done 7 cycles after start
    sweep(8'h10, 100, 8'h15, 1'b1, -1, -1);
    check("hit_tries_abs", 64'(tries), 64'(6));
    // Budget exhaustion
    sweep(8'h00, 5, 8'h00, 1'b0, -1, -1);
    // Wrap FE, FF, 00, 01
    sweep(8'hFE, 10, 8'h01, 1'b1, -1, -1);
    check("wrap_tries_abs", 64'(tries), 64'(4));
    // Zero budget
    sweep(8'h33, 0, 8'h33, 1'b1, -1, -1);
    // Abort in 4th RUN cycle, then sat+abort together
    sweep(8'h80, 50, 8'h00, 1'b0, 3, -1);
    sweep(8'h80, 50, 8'h83, 1'b1, 3, -1);
    check("prio_found_abs", 64'(found), 64'(1));

    // Reset during the 3rd RUN cycle
    sat_en = 1'b0;
    @(negedge clk);
    start = 1'b1; seed = 8'h40; max_tries = 16'd30;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rst_mid_nodone", 64'(done), 64'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rstmid_cand", 64'(cand), 64'(0));
    check("rstmid_hit", 64'(hit_cand), 64'(0));
    check("rstmid_tries", 64'(tries), 64'(0));
    check("rstmid_flags", 64'({cand_valid, busy, done, found}), 64'(0));
    @(negedge clk);
    check("rstmid_idle", 64'({busy, done}), 64'(0));

    // Spurious start during RUN must not restart
    sweep(8'hA0, 20, 8'h00, 1'b0, -1, 2);
    sweep(8'h05, 12, 8'h0B, 1'b1, -1, 4);

    // Randomized sweeps
    for (int n = 0; n < 24; n++) begin
      logic [7:0] s;
      int b, ab, st;
      s  = 8'($urandom);
      b  = $urandom_range(0, 12);
      ab = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 14));
      st = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 10));
      sweep(s, b, s + 8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), ab, st);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
